// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_bit_timer.sv
// Mod-N bit-period timer: counts while enabled, clears synchronously, flags the last tick.
module bit_timer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         roll_o
);

  localparam logic [W-1:0] LastTick = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LastTick) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign roll_o  = en_i && (count_q == LastTick);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a byte as start, LSB-first data, optional parity and stop.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned DIV_WID    = 13,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] din,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_out
);

  localparam int unsigned        CntW     = $clog2(DATA_BITS);
  localparam logic [CntW-1:0]    LastBit  = CntW'(DATA_BITS - 1);
  localparam logic [DIV_WID-1:0] LastTick = DIV_WID'(BAUD_DIV - 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DIV_WID-1:0] tick;
  logic               roll;
  logic               accept;
  logic               timer_en;

  // Ready also opens in the final stop cycle so frames can run back to back.
  assign ready    = (state_q == IDLE) || ((state_q == STOP) && (tick == LastTick));
  assign accept   = send && ready;
  assign timer_en = (state_q != IDLE);

  bit_timer #(
    .N(BAUD_DIV),
    .W(DIV_WID)
  ) u_bit_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (timer_en),
    .clr_i  (accept),
    .count_o(tick),
    .roll_o (roll)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == STOP) && roll;
      if (accept) begin
        state_q   <= START;
        shift_q   <= din;
        bit_cnt_q <= '0;
        parity_q  <= (^din) ^ 1'(PARITY_ODD);
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
      end else if (roll) begin
        unique case (state_q)
          START: begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
          DATA: begin
            if (bit_cnt_q < LastBit) begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              tx_q      <= shift_q[1];
            end else if (PARITY_EN != 0) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              state_q <= STOP;
              tx_q    <= IDLE_LEVEL;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= IDLE_LEVEL;
          end
          STOP: begin
            state_q <= IDLE;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign tx_out = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations checked against a frame-level model every cycle.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] snd;
  logic [7:0] din_a [4];
  logic [4:0] din3;
  logic [3:0] rdy, bsy, dn, txo;

  always #5 clk = ~clk;
  assign din3 = din_a[3][4:0];

  int cfg_baud [4] = '{4, 4, 4, 2};
  int cfg_bits [4] = '{8, 8, 8, 5};
  int cfg_pen  [4] = '{0, 1, 1, 0};
  int cfg_podd [4] = '{0, 0, 1, 0};

  uart_tx_ctrl #(.BAUD_DIV(4), .DIV_WID(13), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .send(snd[0]), .din(din_a[0]),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .tx_out(txo[0]));
  uart_tx_ctrl #(.BAUD_DIV(4), .DIV_WID(13), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .send(snd[1]), .din(din_a[1]),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .tx_out(txo[1]));
  uart_tx_ctrl #(.BAUD_DIV(4), .DIV_WID(13), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .send(snd[2]), .din(din_a[2]),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .tx_out(txo[2]));
  uart_tx_ctrl #(.BAUD_DIV(2), .DIV_WID(13), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .reset(rst[3]), .send(snd[3]), .din(din3),
    .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .tx_out(txo[3]));

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: a frame is a list of line levels, each lasting cfg_baud clocks.
  bit          m_in   [4];
  bit          m_done [4];
  int          m_cyc  [4];
  int          m_len  [4];
  logic [15:0] m_frame[4];

  task automatic model_accept(input int k);
    logic [15:0] f;
    logic        p;
    int          idx;
    f    = '1;
    f[0] = 1'b0;
    p    = cfg_podd[k][0];
    for (int i = 0; i < cfg_bits[k]; i++) begin
      f[1+i] = din_a[k][i];
      p      = p ^ din_a[k][i];
    end
    idx = 1 + cfg_bits[k];
    if (cfg_pen[k] != 0) begin
      f[idx] = p;
      idx++;
    end
    m_frame[k] = f;
    m_len[k]   = (idx + 1) * cfg_baud[k];
    m_cyc[k]   = 0;
    m_in[k]    = 1'b1;
  endtask

  // Compare the current cycle, then advance the model with the inputs the next edge will see.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rst[k]) begin
        check($sformatf("dut%0d reset tx", k), 32'(txo[k]), 32'd1);
        check($sformatf("dut%0d reset busy", k), 32'(bsy[k]), 32'd0);
        check($sformatf("dut%0d reset done", k), 32'(dn[k]), 32'd0);
        check($sformatf("dut%0d reset ready", k), 32'(rdy[k]), 32'd1);
        m_in[k]   = 1'b0;
        m_done[k] = 1'b0;
        m_cyc[k]  = 0;
      end else begin
        check($sformatf("dut%0d tx", k), 32'(txo[k]),
              m_in[k] ? 32'(m_frame[k][m_cyc[k] / cfg_baud[k]]) : 32'd1);
        check($sformatf("dut%0d busy", k), 32'(bsy[k]), 32'(m_in[k]));
        check($sformatf("dut%0d done", k), 32'(dn[k]), 32'(m_done[k]));
        check($sformatf("dut%0d ready", k), 32'(rdy[k]),
              32'(!m_in[k] || (m_cyc[k] == m_len[k] - 1)));
        m_done[k] = 1'b0;
        if (m_in[k]) begin
          if (m_cyc[k] == m_len[k] - 1) begin
            m_done[k] = 1'b1;
            if (snd[k]) model_accept(k);
            else m_in[k] = 1'b0;
          end else begin
            m_cyc[k]++;
          end
        end else if (snd[k]) begin
          model_accept(k);
        end
      end
    end
  end

  logic rec_tx [96];
  logic rec_done [96];
  logic rec_busy [96];
  logic rec_rdy [96];

  task automatic record(input int k, input int j);
    rec_tx[j]   = txo[k];
    rec_done[j] = dn[k];
    rec_busy[j] = bsy[k];
    rec_rdy[j]  = rdy[k];
  endtask

  function automatic int count_ones(input int which, input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) begin
      case (which)
        0:       n += int'(rec_tx[j] === 1'b1);
        1:       n += int'(rec_done[j] === 1'b1);
        2:       n += int'(rec_busy[j] === 1'b1);
        default: n += int'(rec_rdy[j] === 1'b1);
      endcase
    end
    return n;
  endfunction

  // j = 0 is the negedge right after the acceptance edge.
  task automatic run_frame(input int k, input logic [7:0] b, input int n, input int alt_j,
                           input logic [7:0] alt_b);
    @(posedge clk); #1;
    snd[k]   = 1'b1;
    din_a[k] = b;
    @(posedge clk); #1;
    snd[k]   = 1'b0;
    din_a[k] = ~b;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      record(k, j);
      if (j == alt_j) begin
        @(posedge clk); #1;
        snd[k]   = 1'b1;
        din_a[k] = alt_b;
      end else if (j == alt_j + 1) begin
        @(posedge clk); #1;
        snd[k] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp55;
    int         bad;
    exp55 = 10'b1010101010;
    rst = '0;
    snd = '0;
    for (int k = 0; k < 4; k++) din_a[k] = 8'h00;
    #1 rst = '1;
    repeat (3) @(posedge clk);
    #1 rst = '0;
    @(negedge clk);
    check("idle tx", 32'(txo[0]), 32'd1);
    check("idle busy", 32'(bsy[0]), 32'd0);
    check("idle done", 32'(dn[0]), 32'd0);
    check("idle ready", 32'(rdy[0]), 32'd1);

    run_frame(0, 8'h55, 48, -1, 8'h00);
    bad = 0;
    for (int j = 0; j < 40; j++) bad += int'(rec_tx[j] !== exp55[j/4]);
    check("0x55 waveform errors", 32'(bad), 32'd0);
    check("0x55 done count", 32'(count_ones(1, 0, 47)), 32'd1);
    check("0x55 done at 40", 32'(rec_done[40]), 32'd1);
    check("0x55 busy cycles", 32'(count_ones(2, 0, 47)), 32'd40);
    check("0x55 busy low at 40", 32'(rec_busy[40]), 32'd0);

    run_frame(0, 8'h00, 48, 12, 8'hFF);
    check("0x00 data ones", 32'(count_ones(0, 0, 35)), 32'd0);
    check("0x00 stop ones", 32'(count_ones(0, 36, 39)), 32'd4);
    check("0x00 done count", 32'(count_ones(1, 0, 47)), 32'd1);
    check("0x00 done at 40", 32'(rec_done[40]), 32'd1);
    check("0x00 ready during frame", 32'(count_ones(3, 0, 38)), 32'd0);

    @(posedge clk); #1;
    snd[0]   = 1'b1;
    din_a[0] = 8'hA5;
    @(posedge clk); #1;
    din_a[0] = 8'h3C;
    for (int j = 0; j < 90; j++) begin
      @(negedge clk);
      record(0, j);
      if (j == 39) begin
        @(posedge clk); #1;
        snd[0] = 1'b0;
      end
    end
    check("b2b done count", 32'(count_ones(1, 0, 89)), 32'd2);
    check("b2b first done", 32'(rec_done[40]), 32'd1);
    check("b2b second done", 32'(rec_done[80]), 32'd1);
    check("b2b busy cycles", 32'(count_ones(2, 0, 79)), 32'd80);
    check("b2b stop ones", 32'(count_ones(0, 36, 39)), 32'd4);
    check("b2b start ones", 32'(count_ones(0, 40, 43)), 32'd0);

    @(posedge clk); #1;
    snd[0]   = 1'b1;
    din_a[0] = 8'h3C;
    @(posedge clk); #1;
    snd[0] = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("pre-reset tx", 32'(txo[0]), 32'd0);
    rst[0] = 1'b1;
    #1;
    check("async reset tx", 32'(txo[0]), 32'd1);
    check("async reset busy", 32'(bsy[0]), 32'd0);
    check("async reset done", 32'(dn[0]), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    run_frame(0, 8'h96, 48, -1, 8'h00);
    check("post-reset done at 40", 32'(rec_done[40]), 32'd1);
    check("post-reset done count", 32'(count_ones(1, 0, 47)), 32'd1);

    run_frame(1, 8'h07, 48, -1, 8'h00);
    check("even parity bit", 32'(rec_tx[38]), 32'd1);
    check("even done at 44", 32'(rec_done[44]), 32'd1);
    check("even busy at 43", 32'(rec_busy[43]), 32'd1);
    check("even done count", 32'(count_ones(1, 0, 47)), 32'd1);

    run_frame(2, 8'h07, 48, -1, 8'h00);
    check("odd parity bit", 32'(rec_tx[38]), 32'd0);
    check("odd done at 44", 32'(rec_done[44]), 32'd1);

    run_frame(3, 8'h1F, 20, -1, 8'h00);
    check("5bit start ones", 32'(count_ones(0, 0, 1)), 32'd0);
    check("5bit data+stop ones", 32'(count_ones(0, 2, 13)), 32'd12);
    check("5bit done at 14", 32'(rec_done[14]), 32'd1);
    check("5bit busy at 13", 32'(rec_busy[13]), 32'd1);
    check("5bit busy low at 14", 32'(rec_busy[14]), 32'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
